data_mem_resp: RTL and testbench
================================

// Module: data_mem_resp
// PURPOSE
//  Data-memory responder: the memory side of the MEM-stage interface (addr_mem, w_mem,
//  store_data, load_data). Holds a 2**ADDR_W x 32-bit word array, performs byte-enable
//  writes and full-word reads, and answers each accepted request after a configurable
//  number of wait states with a one-cycle ready pulse. The MEM stage does lane select/extend.
// PARAMETERS
//  ADDR_W       8   word-address width; array depth = 2**ADDR_W words of 32 bits
//  WAIT_CYCLES  1   extra wait states per access, 0..15 (4-bit counter)
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  resetn      in   1       asynchronous, active-low reset
//  req         in   1       request valid; sampled only when busy==0
//  addr_mem    in   ADDR_W  word address of the request
//  w_mem       in   4       byte-lane write enables; 4'b0000 = read
//  store_data  in   32      write data, lane i = store_data[8i+7:8i]
//  load_data   out  32      response word; valid while ready==1, held afterwards
//  ready       out  1       one-cycle response pulse
//  busy        out  1       request in flight; req ignored while high
// BEHAVIOUR
//  Reset (resetn=0, async): state=IDLE, cnt=0, ready=0, busy=0, load_data=32'h0.
//   Array contents are not cleared by reset (undefined until written).
//  States: IDLE, WAIT.
//  IDLE: on an edge with req=1, latch addr_mem, w_mem, store_data; cnt<=WAIT_CYCLES;
//   go to WAIT. busy is registered: high from the cycle after acceptance until ready.
//   With req=0, stay in IDLE.
//  WAIT: on each edge with cnt!=0: cnt<=cnt-1.
//   On the edge with cnt==0: perform the access, ready<=1, busy<=0, go to IDLE.
//  Access: for each i with latched w_mem[i]=1, mem[addr][8i+7:8i] <= latched byte i.
//   load_data <= merged word (old bytes where w_mem[i]=0, new bytes where 1).
//   A read (w_mem=0) returns mem[addr] unchanged.
//  Latency: accept edge k -> ready high in the cycle after edge k+WAIT_CYCLES+1.
//   WAIT_CYCLES=0 gives ready in the cycle after edge k+1.
//  ready drops to 0 on the next edge. load_data holds until the next response.
//  Back-to-back: req=1 while ready=1 (state IDLE) is accepted on that edge.
//   Peak throughput is one access per WAIT_CYCLES+2 cycles.
//  Inputs are sampled only at acceptance; changes during WAIT have no effect.
//  Address wrap: none. addr_mem is the full word index, so every value is legal.
//  Reset during WAIT: the request is aborted and no array write occurs. The bus returns
//   to reset values, and the requester must reissue.
//  Partial enables (e.g. 4'b0011, 4'b1100, 4'b0100) are legal. Only the enabled lanes change.
// TESTING
//  1 Reset: resetn=0 mid-run -> ready=0, busy=0, load_data=0 immediately (async).
//  2 Full write then read, WAIT_CYCLES=1: write addr 8'h10, w_mem=4'hF, data 32'hDEADBEEF.
//    ready comes 2 cycles after the accept edge, with load_data=DEADBEEF.
//    A later read of 8'h10 returns DEADBEEF.
//  3 Byte merge: addr 8'h10 holds DEADBEEF; write w_mem=4'b0100, data 32'h00A50000.
//    load_data=DEA5BEEF; a following read returns DEA5BEEF.
//    Then w_mem=4'b0011, data 32'h00001234 -> DEA51234.
//  4 Back-to-back: hold req=1 with reads of 8'h00 then 8'h01 -> each is accepted in
//    its ready cycle, giving 3-cycle spacing. busy blocks any req during WAIT.
//  5 Reset during WAIT: write 8'h20 with 32'h11111111; assert resetn=0 before ready,
//    then release. A read of 8'h20 returns the previously written 32'h0.
//  6 WAIT_CYCLES=0 and WAIT_CYCLES=15 builds: ready arrives 1 and 16 cycles after
//    the accept edge. Inputs changed during WAIT do not alter the result.

Source files
------------

// File: rtl/data_mem_resp.sv
// Data-memory responder for the MEM stage: byte-enable writes, full-word reads,
// answered with a one-cycle ready pulse after WAIT_CYCLES extra wait states.
module data_mem_resp #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr_mem,
  input  logic [3:0]        w_mem,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              ready,
  output logic              busy
);

  // state  | meaning
  // S_IDLE | waiting for req; also the ready cycle, so back-to-back requests are taken here
  // S_WAIT | request latched, counting wait states, access on the edge with cnt==0
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [0:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wen_q, wen_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] merged;
  logic        do_access;

  // Old bytes where the lane is disabled, new bytes where enabled; a read is the old word.
  always_comb begin
    merged = mem[addr_q];
    for (int i = 0; i < 4; i++) begin
      if (wen_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    ready_d     = 1'b0;
    busy_d      = busy_q;
    do_access   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr_mem;
          wen_d   = w_mem;
          wdata_d = store_data;
          cnt_d   = WAIT_INIT;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          do_access   = 1'b1;
          load_data_d = merged;
          ready_d     = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wen_q       <= 4'd0;
      wdata_q     <= 32'h0;
      load_data_q <= 32'h0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  // Array is deliberately not reset; an aborted request never reaches this write.
  always_ff @(posedge clk) begin
    if (do_access && (wen_q != 4'd0)) mem[addr_q] <= merged;
  end

  assign load_data = load_data_q;
  assign ready     = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: three builds (WAIT_CYCLES = 1, 0, 15) on one clock.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  req_v = 3'b000;
  logic [2:0]  rdy_v;
  logic [2:0]  bsy_v;
  logic [7:0]  addr_v [3];
  logic [3:0]  wm_v   [3];
  logic [31:0] sd_v   [3];
  logic [31:0] ld_v   [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_resp #(.ADDR_W(8), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .resetn(resetn), .req(req_v[0]), .addr_mem(addr_v[0]), .w_mem(wm_v[0]),
    .store_data(sd_v[0]), .load_data(ld_v[0]), .ready(rdy_v[0]), .busy(bsy_v[0]));

  data_mem_resp #(.ADDR_W(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .resetn(resetn), .req(req_v[1]), .addr_mem(addr_v[1]), .w_mem(wm_v[1]),
    .store_data(sd_v[1]), .load_data(ld_v[1]), .ready(rdy_v[1]), .busy(bsy_v[1]));

  data_mem_resp #(.ADDR_W(8), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .resetn(resetn), .req(req_v[2]), .addr_mem(addr_v[2]), .w_mem(wm_v[2]),
    .store_data(sd_v[2]), .load_data(ld_v[2]), .ready(rdy_v[2]), .busy(bsy_v[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on instance idx; lat = edges after the accept edge until ready, -1 on timeout.
  task automatic issue(input int idx, input logic [7:0] a, input logic [3:0] w,
                       input logic [31:0] d, input bit scramble,
                       output int lat, output logic [31:0] q);
    req_v[idx]  = 1'b1;
    addr_v[idx] = a;
    wm_v[idx]   = w;
    sd_v[idx]   = d;
    tick();
    req_v[idx] = 1'b0;
    if (scramble) begin
      addr_v[idx] = ~a;
      wm_v[idx]   = ~w;
      sd_v[idx]   = ~d;
    end
    lat = -1;
    q   = 32'hxxxxxxxx;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (rdy_v[idx]) begin
        lat = i;
        q   = ld_v[idx];
        break;
      end
    end
  endtask

  task automatic test_full_write_read();
    int lat;
    logic [31:0] q;
    issue(0, 8'h10, 4'hF, 32'hDEADBEEF, 1'b0, lat, q);
    total++; if (lat !== 2) begin bad++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    total++; if (q !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_data got=%h exp=deadbeef", q); end
    tick();
    total++; if (rdy_v[0] !== 1'b0) begin bad++; $display("FAIL ready_pulse got=%b exp=0", rdy_v[0]); end
    total++; if (ld_v[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL load_hold got=%h exp=deadbeef", ld_v[0]); end
    issue(0, 8'h10, 4'h0, 32'h0, 1'b0, lat, q);
    total++; if (q !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_10 got=%h exp=deadbeef", q); end
    tick();
  endtask

  task automatic test_byte_merge();
    int lat;
    logic [31:0] q;
    issue(0, 8'h10, 4'b0100, 32'h00A50000, 1'b0, lat, q);
    total++; if (q !== 32'hDEA5BEEF) begin bad++; $display("FAIL merge_0100 got=%h exp=dea5beef", q); end
    tick();
    issue(0, 8'h10, 4'b0000, 32'hFFFFFFFF, 1'b0, lat, q);
    total++; if (q !== 32'hDEA5BEEF) begin bad++; $display("FAIL rd_merge got=%h exp=dea5beef", q); end
    tick();
    issue(0, 8'h10, 4'b0011, 32'h00001234, 1'b0, lat, q);
    total++; if (q !== 32'hDEA51234) begin bad++; $display("FAIL merge_0011 got=%h exp=dea51234", q); end
    tick();
    issue(0, 8'h10, 4'b1000, 32'h7700FFFF, 1'b0, lat, q);
    total++; if (q !== 32'h77A51234) begin bad++; $display("FAIL merge_1000 got=%h exp=77a51234", q); end
    tick();
  endtask

  task automatic test_reset();
    total++; if (ld_v[0] === 32'h0) begin bad++; $display("FAIL reset_pre load got=%h exp=nonzero", ld_v[0]); end
    #2 resetn = 1'b0;
    #1;
    total++; if (ld_v[0] !== 32'h0) begin bad++; $display("FAIL reset_load got=%h exp=0", ld_v[0]); end
    total++; if (rdy_v[0] !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", rdy_v[0]); end
    total++; if (bsy_v[0] !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bsy_v[0]); end
    #3 resetn = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] q;
    issue(0, 8'h00, 4'hF, 32'h0000AAAA, 1'b0, lat, q);
    tick();
    issue(0, 8'h01, 4'hF, 32'h55550001, 1'b0, lat, q);
    tick();
    req_v[0] = 1'b1; addr_v[0] = 8'h00; wm_v[0] = 4'h0; sd_v[0] = 32'hFFFFFFFF;
    tick();
    total++; if (bsy_v[0] !== 1'b1) begin bad++; $display("FAIL b2b_busy1 got=%b exp=1", bsy_v[0]); end
    addr_v[0] = 8'h01;
    tick();
    total++; if (rdy_v[0] !== 1'b0 || bsy_v[0] !== 1'b1) begin
      bad++; $display("FAIL b2b_blocked ready=%b busy=%b exp ready=0 busy=1", rdy_v[0], bsy_v[0]);
    end
    tick();
    total++; if (rdy_v[0] !== 1'b1) begin bad++; $display("FAIL b2b_rdy1 got=%b exp=1", rdy_v[0]); end
    total++; if (ld_v[0] !== 32'h0000AAAA) begin bad++; $display("FAIL b2b_data1 got=%h exp=0000aaaa", ld_v[0]); end
    tick();
    total++; if (rdy_v[0] !== 1'b0 || bsy_v[0] !== 1'b1) begin
      bad++; $display("FAIL b2b_accept2 ready=%b busy=%b exp ready=0 busy=1", rdy_v[0], bsy_v[0]);
    end
    req_v[0] = 1'b0;
    tick();
    total++; if (rdy_v[0] !== 1'b0) begin bad++; $display("FAIL b2b_early got=%b exp=0", rdy_v[0]); end
    tick();
    total++; if (rdy_v[0] !== 1'b1) begin bad++; $display("FAIL b2b_rdy2 got=%b exp=1", rdy_v[0]); end
    total++; if (ld_v[0] !== 32'h55550001) begin bad++; $display("FAIL b2b_data2 got=%h exp=55550001", ld_v[0]); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    int lat;
    logic [31:0] q;
    issue(0, 8'h20, 4'hF, 32'h0, 1'b0, lat, q);
    tick();
    req_v[0] = 1'b1; addr_v[0] = 8'h20; wm_v[0] = 4'hF; sd_v[0] = 32'h11111111;
    tick();
    req_v[0] = 1'b0;
    tick();
    total++; if (bsy_v[0] !== 1'b1) begin bad++; $display("FAIL abort_busy_pre got=%b exp=1", bsy_v[0]); end
    #2 resetn = 1'b0;
    #1;
    total++; if (bsy_v[0] !== 1'b0 || rdy_v[0] !== 1'b0) begin
      bad++; $display("FAIL abort_outputs busy=%b ready=%b exp 0 0", bsy_v[0], rdy_v[0]);
    end
    #12 resetn = 1'b1;
    tick();
    total++; if (rdy_v[0] !== 1'b0) begin bad++; $display("FAIL abort_no_ready got=%b exp=0", rdy_v[0]); end
    issue(0, 8'h20, 4'h0, 32'h0, 1'b0, lat, q);
    total++; if (q !== 32'h0) begin bad++; $display("FAIL abort_rd_20 got=%h exp=00000000", q); end
    tick();
  endtask

  task automatic test_wait_builds();
    int lat;
    logic [31:0] q;
    issue(1, 8'h33, 4'hF, 32'hCAFEF00D, 1'b1, lat, q);
    total++; if (lat !== 1) begin bad++; $display("FAIL w0_latency got=%0d exp=1", lat); end
    total++; if (q !== 32'hCAFEF00D) begin bad++; $display("FAIL w0_data got=%h exp=cafef00d", q); end
    tick();
    issue(1, 8'h33, 4'h0, 32'h0, 1'b1, lat, q);
    total++; if (q !== 32'hCAFEF00D) begin bad++; $display("FAIL w0_rd got=%h exp=cafef00d", q); end
    tick();
    issue(2, 8'h44, 4'hF, 32'h12345678, 1'b1, lat, q);
    total++; if (lat !== 16) begin bad++; $display("FAIL w15_latency got=%0d exp=16", lat); end
    total++; if (q !== 32'h12345678) begin bad++; $display("FAIL w15_data got=%h exp=12345678", q); end
    tick();
    issue(2, 8'h44, 4'h0, 32'h0, 1'b1, lat, q);
    total++; if (lat !== 16 || q !== 32'h12345678) begin
      bad++; $display("FAIL w15_rd lat=%0d data=%h exp 16 12345678", lat, q);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = 8'h0;
      wm_v[i]   = 4'h0;
      sd_v[i]   = 32'h0;
    end
    #1;
    total++; if (ld_v[0] !== 32'h0 || rdy_v[0] !== 1'b0 || bsy_v[0] !== 1'b0) begin
      bad++; $display("FAIL init_reset load=%h ready=%b busy=%b exp 0 0 0", ld_v[0], rdy_v[0], bsy_v[0]);
    end
    #16 resetn = 1'b1;
    tick();
    test_full_write_read();
    test_byte_merge();
    test_reset();
    test_back_to_back();
    test_reset_in_wait();
    test_wait_builds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
